event_counter_bank: RTL
=======================

# event_counter_bank

Parametrised multi-channel event capture block: each of NCH single-bit inputs is synchronised, edge-detected per a selectable mode and counted in a saturating per-channel counter. Non-zero counts are drained one channel at a time through a registered valid/ready output, with round-robin fairness and snapshot-and-clear semantics. It sits between raw asynchronous status lines and the control/status logic that consumes event totals.

## Interface
- NCH, 4, number of input channels (1..32)
- CNT_W, 8, counter width per channel (2..16)
- EDGE_MODE, 0, 0 = rising, 1 = falling, 2 = both edges
- SYNC_STAGES, 2, synchroniser depth per input (2..4)
- CH_W, derived, clog2(NCH) with minimum 1; not overridable

Ports:
- CLK  input  1  single clock; all logic on posedge
- RST  input  1  asynchronous, active-low reset
- IN  input  NCH  raw event lines, asynchronous to CLK
- CLR  input  1  synchronous clear of counts, overflow flags, output and arbiter pointer
- OUT_VALID  output  1  OUT_CH/OUT_CNT hold a valid snapshot
- OUT_READY  input  1  consumer accepts the snapshot when high together with OUT_VALID
- OUT_CH  output  CH_W  channel index of the snapshot
- OUT_CNT  output  CNT_W  event count of the snapshot, always non-zero when valid
- OVF  output  NCH  sticky per-channel saturation flag

## Operation
- Per channel: shift register sync[0..SYNC_STAGES-1], plus prev register. prev <= sync[last] every cycle.
- Event, combinational: rise = sync[last] & ~prev; fall = ~sync[last] & prev; both = the XOR of the two.
- Counter: event and cnt < 2^CNT_W-1 -> cnt+1. Event and cnt saturated -> cnt holds, OVF[ch] <= 1. OVF clears only on CLR or reset.
- Output register states: EMPTY (OUT_VALID=0) and HOLD (OUT_VALID=1).
- Load condition: EMPTY, or HOLD with OUT_READY=1. On load, pick the first channel with cnt != 0, searching from ptr+1 upward and wrapping modulo NCH.
- On a load of channel c: OUT_CH <= c, OUT_CNT <= cnt[c], ptr <= c, OUT_VALID <= 1. cnt[c] <= 1 if an event on c occurs in the same cycle, else 0.
- Load condition true and no channel non-zero -> OUT_VALID <= 0.
- While in HOLD with OUT_READY=0, OUT_CH and OUT_CNT stay stable. Counts keep accumulating in the channel counters.
- CLR: cnt, OVF, OUT_VALID and ptr go to 0. Events in the CLR cycle are dropped. sync/prev are not cleared.
- Reset (RST=0, asynchronous): all sync, prev, cnt, OVF, ptr, OUT_VALID, OUT_CH and OUT_CNT go to 0.
  - Rising mode: an IN held high through reset release counts exactly one event. Defined, not a bug.
  - Reset mid-transfer discards the pending snapshot.

## Timing
- IN change meeting setup before edge k -> event high in the cycle after edge k+SYNC_STAGES-1 -> cnt updated at edge k+SYNC_STAGES.
- Earliest OUT_VALID at edge k+SYNC_STAGES+1 (SYNC_STAGES=2: three edges after the input change).
- Handshake completes at any edge where OUT_VALID & OUT_READY. The next snapshot can be presented at that same edge, giving back-to-back throughput of one snapshot per cycle.
- IN pulses shorter than two CLK periods may be missed. No guarantee is given.
- OUT_* and OVF are driven directly from flops. There are no combinational paths from any input to any output.

## Structure
- Package event_counter_pkg holds:
  - EDGE_RISE, EDGE_FALL and EDGE_BOTH constants
  - a clog2 function used for CH_W
  - the saturation-max helper function
- Sub-module event_chan, one instance per channel, generate-looped. It contains sync, prev, edge select, the saturating counter and the OVF flop. Inputs are take (snapshot clear) and clr. Outputs are cnt, ovf and event.
- Top level holds the round-robin pick, the output register and ptr.

## Test plan
- Reset with IN=0, NCH=4, EDGE_MODE=0: 3 rising pulses on IN[2], OUT_READY=1 -> OUT_CH=2 and OUT_CNT=1, once per pulse. Each appears exactly SYNC_STAGES+1 edges after its pulse.
- OUT_READY=0: 5 pulses on IN[1] -> OUT_VALID with OUT_CNT=1 held stable. Raise READY -> second snapshot OUT_CH=1, OUT_CNT=4.
- CNT_W=2, READY=0, 6 pulses on IN[0] -> the snapshot after the first holds 3 and OVF[0]=1. CLR -> OVF=0 and OUT_VALID=0.
- Simultaneous single pulses on all 4 channels, READY=1, ptr=0 after reset -> OUT_CH sequence 1,2,3,0 on consecutive cycles, each with OUT_CNT=1.
- EDGE_MODE=2: one high pulse on IN[3] -> total count 2. Event coinciding with take cycle -> next snapshot OUT_CNT=1, no event lost.
- Assert RST while OUT_VALID=1 and counts non-zero -> all outputs 0 immediately. After release with IN=0, no OUT_VALID.

Source files
------------

// File: rtl/event_counter_pkg.sv
// Shared constants, output-register state encoding and sizing helpers
// for the event counter bank.
package event_counter_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_e;

  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int unsigned i = 0; i < 32'd31; i++) begin
      if ((32'd1 << i) < value) begin
        result = int'(i) + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Channel index width never drops below one bit, even for a single channel.
  function automatic int ch_width(input int unsigned n);
    return (n <= 32'd1) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/event_chan.sv
// One event channel: input synchroniser, edge detector, saturating counter
// and sticky overflow flag.
module event_chan
  import event_counter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_i,
  input  logic             clr_i,
  input  logic             take_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o,
  output logic             event_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   rise_s, fall_s, event_s;

  // Synchroniser chain and previous-sample flop; never touched by clr.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_s = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_s = ~sync_q[SYNC_STAGES-1] & prev_q;

  // Edge select for the configured mode.
  always_comb begin
    case (EDGE_MODE)
      EDGE_FALL: event_s = fall_s;
      EDGE_BOTH: event_s = rise_s ^ fall_s;
      default:   event_s = rise_s;
    endcase
  end

  // Counter next state: clear wins, then snapshot take, then counting.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (take_i) begin
      // An event landing in the take cycle seeds the fresh count.
      cnt_d = event_s ? CNT_W'(1) : '0;
    end else if (event_s) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and overflow state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;
  assign event_o = event_s;

endmodule

// File: rtl/event_counter_bank.sv
// Multi-channel event counter bank with round-robin snapshot-and-clear
// drain through a registered valid/ready output.
module event_counter_bank
  import event_counter_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = 8,
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = ch_width(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NCH-1:0]   in_i,
  input  logic             clr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CH_W-1:0]  out_ch_o,
  output logic [CNT_W-1:0] out_cnt_o,
  output logic [NCH-1:0]   ovf_o
);

  logic [CNT_W-1:0] cnt_s [NCH];
  logic [NCH-1:0]   ovf_s;
  logic [NCH-1:0]   event_s;
  logic [NCH-1:0]   take_s;
  logic             unused_event_s;

  out_state_e       state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             load_s;
  logic             take_en_s;
  logic             found_s;
  logic [CH_W-1:0]  pick_s;
  logic [CNT_W-1:0] pick_cnt_s;
  int               idx_s;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    event_chan #(
      .CNT_W      (CNT_W),
      .EDGE_MODE  (EDGE_MODE),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .in_i   (in_i[g]),
      .clr_i  (clr_i),
      .take_i (take_s[g]),
      .cnt_o  (cnt_s[g]),
      .ovf_o  (ovf_s[g]),
      .event_o(event_s[g])
    );

    assign take_s[g] = take_en_s && (pick_s == CH_W'(g));
  end

  // The per-channel take path already folds in same-cycle events.
  assign unused_event_s = ^event_s;

  // Round-robin search: first non-zero counter after ptr, wrapping.
  always_comb begin
    found_s    = 1'b0;
    pick_s     = '0;
    pick_cnt_s = '0;
    idx_s      = 0;
    for (int i = 1; i <= NCH; i++) begin
      idx_s = (int'(ptr_q) + i) % NCH;
      if (!found_s && (cnt_s[idx_s] != '0)) begin
        found_s    = 1'b1;
        pick_s     = CH_W'(idx_s);
        pick_cnt_s = cnt_s[idx_s];
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Output register next state and snapshot take.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    out_ch_d  = out_ch_q;
    out_cnt_d = out_cnt_q;
    take_en_s = 1'b0;
    case (state_q)
      ST_EMPTY: load_s = 1'b1;
      ST_HOLD:  load_s = out_ready_i;
      default:  load_s = 1'b1;
    endcase
    if (clr_i) begin
      state_d   = ST_EMPTY;
      ptr_d     = '0;
      out_ch_d  = '0;
      out_cnt_d = '0;
    end else if (load_s) begin
      if (found_s) begin
        state_d   = ST_HOLD;
        ptr_d     = pick_s;
        out_ch_d  = pick_s;
        out_cnt_d = pick_cnt_s;
        take_en_s = 1'b1;
      end else begin
        state_d   = ST_EMPTY;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output register, arbiter pointer and state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_EMPTY;
      ptr_q     <= '0;
      out_ch_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_ch_q  <= out_ch_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign out_valid_o = (state_q == ST_HOLD);
  assign out_ch_o    = out_ch_q;
  assign out_cnt_o   = out_cnt_q;
  assign ovf_o       = ovf_s;

endmodule
